// File: rtl/alu_operand_loader.sv
// Operand input stage for the ALU. Pressing the load button captures operand A, then
// operand B, then the opcode from the switches. The clear button empties the set.
module alu_operand_loader #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned OP_W            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             btn_load_i,
  input  logic             btn_clear_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [OP_W-1:0]  op_o,
  output logic             valid_o,
  output logic [1:0]       state_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StA     = 2'b00,
    StB     = 2'b01,
    StOp    = 2'b10,
    StReady = 2'b11
  } state_e;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      deb_dly_q;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic            load_pulse, clear_pulse;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             valid_q, valid_d;

  assign btn_raw = {btn_clear_i, btn_load_i};

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign load_pulse  = deb_q[0] & ~deb_dly_q[0];
  assign clear_pulse = deb_q[1] & ~deb_dly_q[1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (clear_pulse) begin
      // Clear takes priority over a coincident load.
      state_d = StA;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (load_pulse) begin
      unique case (state_q)
        StA: begin
          a_d     = sw_i;
          state_d = StB;
        end
        StB: begin
          b_d     = sw_i;
          state_d = StOp;
        end
        StOp: begin
          op_d    = sw_i[OP_W-1:0];
          valid_d = 1'b1;
          state_d = StReady;
        end
        StReady: begin
          // New A restarts the sequence; B and opcode are kept until overwritten.
          a_d     = sw_i;
          valid_d = 1'b0;
          state_d = StB;
        end
        default: state_d = StA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign op_o    = op_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with a short debounce window: table vectors, hand-written
// corner sequences and randomized presses against a behavioural model.
`timescale 1ns/1ps
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_i;
  logic       btn_load_i, btn_clear_i;
  logic [3:0] a_o, b_o, op_o;
  logic       valid_o;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_a, m_b, m_op;
  logic       m_valid;
  logic [1:0] m_st;

  typedef struct {
    logic       clr;
    logic [3:0] sw;
    logic [3:0] a, b, op;
    logic       valid;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[9];

  alu_operand_loader #(
    .WIDTH(4),
    .OP_W(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_i       (sw_i),
    .btn_load_i (btn_load_i),
    .btn_clear_i(btn_clear_i),
    .a_o        (a_o),
    .b_o        (b_o),
    .op_o       (op_o),
    .valid_o    (valid_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input logic v, input logic [1:0] st);
    chk({tag, ".a"}, 32'(a_o), 32'(a));
    chk({tag, ".b"}, 32'(b_o), 32'(b));
    chk({tag, ".op"}, 32'(op_o), 32'(op));
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".state"}, 32'(state_o), 32'(st));
  endtask

  // Hold the buttons long enough to register, then release long enough to settle low.
  task automatic press(input logic ld, input logic cl, input logic [3:0] sw);
    sw_i        = sw;
    btn_load_i  = ld;
    btn_clear_i = cl;
    step(12);
    btn_load_i  = 1'b0;
    btn_clear_i = 1'b0;
    step(12);
  endtask

  // Load press whose capture must land exactly on the 7th edge.
  task automatic timed_load(input string tag, input logic [3:0] sw,
                            input logic [1:0] st_before, input logic [1:0] st_after);
    sw_i       = sw;
    btn_load_i = 1'b1;
    step(6);
    chk({tag, ".edge6"}, 32'(state_o), 32'(st_before));
    step(1);
    chk({tag, ".edge7"}, 32'(state_o), 32'(st_after));
    step(5);
    btn_load_i = 1'b0;
    step(12);
  endtask

  task automatic model_clear();
    m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_st = 2'd0;
  endtask

  task automatic model_load(input logic [3:0] sw);
    case (m_st)
      2'd0: begin m_a = sw; m_st = 2'd1; end
      2'd1: begin m_b = sw; m_st = 2'd2; end
      2'd2: begin m_op = sw; m_valid = 1'b1; m_st = 2'd3; end
      default: begin m_a = sw; m_valid = 1'b0; m_st = 2'd1; end
    endcase
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b01};
    vecs[1] = '{1'b0, 4'b0011, 4'b0101, 4'b0011, 4'b0000, 1'b0, 2'b10};
    vecs[2] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'b01};
    vecs[4] = '{1'b0, 4'b0110, 4'b1010, 4'b0110, 4'b0000, 1'b0, 2'b10};
    vecs[5] = '{1'b0, 4'b1001, 4'b1010, 4'b0110, 4'b1001, 1'b1, 2'b11};
    vecs[6] = '{1'b0, 4'b0001, 4'b0001, 4'b0110, 4'b1001, 1'b0, 2'b01};
    vecs[7] = '{1'b0, 4'b1100, 4'b0001, 4'b1100, 4'b1001, 1'b0, 2'b10};
    vecs[8] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00};

    rst_n       = 1'b0;
    sw_i        = '0;
    btn_load_i  = 1'b0;
    btn_clear_i = 1'b0;
    step(2);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    rst_n = 1'b1;
    step(2);

    // Full capture sequence with exact latency
    timed_load("cap_a", 4'b0101, 2'b00, 2'b01);
    timed_load("cap_b", 4'b0011, 2'b01, 2'b10);
    timed_load("cap_op", 4'b0010, 2'b10, 2'b11);
    chk_all("capture", 4'b0101, 4'b0011, 4'b0010, 1'b1, 2'b11);

    press(1'b1, 1'b0, 4'b1111);
    chk_all("ready_reload", 4'b1111, 4'b0011, 4'b0010, 1'b0, 2'b01);
    press(1'b0, 1'b1, 4'b0000);
    chk_all("clear_b", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);

    for (int i = 0; i < 9; i++) begin
      press(~vecs[i].clr, vecs[i].clr, vecs[i].sw);
      chk_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].valid,
              vecs[i].st);
    end

    // Bounce shorter than the window is ignored; a sustained press advances once
    sw_i = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      btn_load_i = 1'b1;
      step(3);
      btn_load_i = 1'b0;
      step(1);
    end
    chk("bounce.state", 32'(state_o), 32'(2'b00));
    chk("bounce.a", 32'(a_o), 32'(4'b0000));
    btn_load_i = 1'b1;
    step(50);
    chk("hold.state", 32'(state_o), 32'(2'b01));
    chk("hold.a", 32'(a_o), 32'(4'b0111));
    btn_load_i = 1'b0;
    step(12);
    chk("release.state", 32'(state_o), 32'(2'b01));

    // Simultaneous load and clear in S_B
    press(1'b1, 1'b1, 4'b1110);
    chk_all("simul", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);

    // Asynchronous reset mid-debounce in S_B
    press(1'b1, 1'b0, 4'b0101);
    chk("pre_rst.state", 32'(state_o), 32'(2'b01));
    sw_i       = 4'b1100;
    btn_load_i = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    btn_load_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk_all("post_rst", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    press(1'b1, 1'b0, 4'b1100);
    chk_all("rst_recap", 4'b1100, 4'h0, 4'h0, 1'b0, 2'b01);

    // Randomized presses against the model
    press(1'b0, 1'b1, 4'h0);
    model_clear();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] sw;
      sw = 4'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        press(1'b0, 1'b1, sw);
        model_clear();
      end else begin
        press(1'b1, 1'b0, sw);
        model_load(sw);
      end
      chk_all($sformatf("rand%0d", i), m_a, m_b, m_op, m_valid, m_st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
